fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters, one per line:
  - XLEN, 32, instruction width
  - PC_BITS, 5, PC width; the PC is a word index
  - NOP_INST, 32'h00000013, bubble instruction
REQ-002 Ports, one per line (name, direction, width, meaning):
  - clk  in  1  sole clock; all state updates on its rising edge
  - rst  in  1  synchronous, active-high reset
  - stall_F  in  1  downstream not accepting; same signal that gates the F->D register
  - redirect_valid  in  1  PC redirect (taken branch/jump) request
  - redirect_pc  in  PC_BITS  redirect target
  - imem_req  out  1  one-cycle instruction read request
  - imem_addr  out  PC_BITS  read address, valid when imem_req=1
  - imem_rdata  in  XLEN  read data
  - imem_rvalid  in  1  read data valid, latency >=1 cycle after imem_req
  - F_pc  out  PC_BITS  PC of presented instruction
  - F_inst  out  XLEN  presented instruction
  - F_valid  out  1  F_pc/F_inst hold a real instruction
  - perf_fetched  out  16  delivered-instruction count (see Configuration)
REQ-003 F_pc, F_inst, F_valid, perf_fetched SHALL be registered; imem_req and imem_addr SHALL be combinational from state, pc, stall_F and redirect_valid.

Function
REQ-004 The block SHALL implement states S_REQ, S_WAIT, S_HOLD and S_DRAIN, plus an internal register pc.
REQ-005 S_REQ: imem_req=1, imem_addr=pc; next state S_WAIT.
REQ-006 S_WAIT: imem_rvalid=0 -> stay. imem_rvalid=1 -> F_inst<=imem_rdata, F_pc<=pc, F_valid<=1, pc<=pc+1, next S_HOLD.
REQ-007 S_HOLD with stall_F=1: all outputs and pc SHALL hold; imem_req=0.
REQ-008 S_HOLD with stall_F=0: the instruction is consumed; imem_req=1, imem_addr=pc, F_valid<=0, F_inst<=NOP_INST; next S_WAIT.
REQ-009 Best-case throughput SHALL be one instruction per 2 cycles with 1-cycle memory latency.
REQ-010 Whenever F_valid=0, F_inst SHALL equal NOP_INST.
REQ-011 pc+1 SHALL wrap modulo 2^PC_BITS (31 -> 0 at PC_BITS=5).
REQ-012 redirect_valid=1 SHALL take priority over stall_F and imem_rvalid in every state:
  - pc<=redirect_pc
  - F_valid<=0, F_inst<=NOP_INST
  - imem_req=0 that cycle
REQ-013 Next state on redirect:
  - from S_REQ or S_HOLD -> S_REQ
  - from S_WAIT with imem_rvalid=0 -> S_DRAIN
  - from S_WAIT with imem_rvalid=1 -> S_REQ, response discarded
  - from S_DRAIN -> S_DRAIN with pc updated, or S_REQ if imem_rvalid=1
REQ-014 S_DRAIN: the next imem_rvalid SHALL be discarded and the state SHALL go to S_REQ; imem_req=0 while in S_DRAIN.
REQ-015 imem_rvalid in S_REQ or S_HOLD SHALL be ignored.
REQ-016 At most one memory request SHALL be outstanding at any time.

Reset
REQ-017 On clk edge with rst=1, the block SHALL set:
  - pc=0, state=S_REQ
  - F_pc=0, F_inst=NOP_INST, F_valid=0
  - perf_fetched=0
REQ-018 rst SHALL override redirect, stall and rvalid; a request outstanding at reset SHALL be abandoned, and the memory shares rst and drops it.
REQ-019 The first imem_req SHALL assert, with imem_addr=0, in the first cycle after rst deasserts.

Configuration
REQ-020 Macro FETCH_PERF_EN:
  - defined: perf_fetched SHALL increment on each cycle with state=S_HOLD, stall_F=0 and redirect_valid=0, saturating at 16'hFFFF
  - undefined: perf_fetched SHALL be constant 0, with no counter logic present

Verification
REQ-021 Bench SHALL use PC_BITS=5 and a memory returning mem[a]=32'h1000_0000+a with 1-cycle latency.
REQ-022 Directed scenarios:
  - Reset release, stall_F=0 -> imem_addr 0,1,2 on cycles 1,3,5; F_valid pulses carry F_pc=0,1,2 with F_inst=10000000,10000001,10000002.
  - stall_F=1 for 4 cycles in S_HOLD at F_pc=3 -> F_pc=3, F_inst=10000003, F_valid=1 held; no imem_req.
  - Redirect to 17 in S_WAIT while memory delays 3 cycles -> stale rvalid dropped; next imem_addr=17; next delivered F_inst=10000011.
  - Redirect to 9 together with stall_F=1 in S_HOLD -> F_valid=0, F_inst=NOP_INST next cycle; next imem_addr=9.
  - Redirect to 31 then free run -> delivered PCs 31,0,1 in order.
  - With FETCH_PERF_EN defined, 5 deliveries interleaved with 3 stalled cycles and 1 redirect -> perf_fetched=5; undefined -> 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, F->D presentation register, redirect handling.
// Optional delivered-instruction counter enabled by defining FETCH_PERF_EN.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter int              PC_BITS  = 5,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_F,
  input  logic               redirect_valid,
  input  logic [PC_BITS-1:0] redirect_pc,
  output logic               imem_req,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  input  logic               imem_rvalid,
  output logic [PC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]    F_inst,
  output logic               F_valid,
  output logic [15:0]        perf_fetched
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [PC_BITS-1:0] f_pc_q, f_pc_d;
  logic [XLEN-1:0]    f_inst_q, f_inst_d;
  logic               f_valid_q, f_valid_d;

  // A request goes out on entry (S_REQ) or when the held instruction is consumed.
  assign imem_req  = !redirect_valid &&
                     ((state_q == S_REQ) || ((state_q == S_HOLD) && !stall_F));
  assign imem_addr = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    f_pc_d    = f_pc_q;
    f_inst_d  = f_inst_q;
    f_valid_d = f_valid_q;
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      f_valid_d = 1'b0;
      f_inst_d  = NOP_INST;
      // A read still in flight must be drained so its data is never presented.
      case (state_q)
        S_WAIT, S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
        default:         state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            f_inst_d  = imem_rdata;
            f_pc_d    = pc_q;
            f_valid_d = 1'b1;
            pc_d      = pc_q + 1'b1;
            state_d   = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall_F) begin
            f_valid_d = 1'b0;
            f_inst_d  = NOP_INST;
            state_d   = S_WAIT;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= '0;
      f_pc_q    <= '0;
      f_inst_q  <= NOP_INST;
      f_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      f_pc_q    <= f_pc_d;
      f_inst_q  <= f_inst_d;
      f_valid_q <= f_valid_d;
    end
  end

  assign F_pc    = f_pc_q;
  assign F_inst  = f_inst_q;
  assign F_valid = f_valid_q;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Counts instructions actually handed downstream, saturating.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_HOLD) && !stall_F && !redirect_valid && (perf_q != 16'hFFFF))
      perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_fetched = perf_q;
`else
  assign perf_fetched = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized run against a transaction-level model.
module tb_fetch_stage;
  localparam int          XLEN    = 32;
  localparam int          PC_BITS = 5;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] BASE    = 32'h1000_0000;
`ifdef FETCH_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               stall_F = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [PC_BITS-1:0] redirect_pc = '0;
  logic               imem_req;
  logic [PC_BITS-1:0] imem_addr;
  logic [XLEN-1:0]    imem_rdata;
  logic               imem_rvalid;
  logic [PC_BITS-1:0] F_pc;
  logic [XLEN-1:0]    F_inst;
  logic               F_valid;
  logic [15:0]        perf_fetched;

  int errors = 0;
  int checks = 0;

  // memory model: mem[a] = BASE + a, latency mem_lat cycles, shares rst
  int                 mem_lat = 1;
  int                 mem_cnt = 0;
  int                 overlap = 0;
  logic [PC_BITS-1:0] mem_addr = '0;

  fetch_stage #(.XLEN(XLEN), .PC_BITS(PC_BITS), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall_F(stall_F), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .F_pc(F_pc),
    .F_inst(F_inst), .F_valid(F_valid), .perf_fetched(perf_fetched)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mem_cnt     <= 0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (mem_cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= BASE + 32'(mem_addr);
      end
      if (mem_cnt != 0) mem_cnt <= mem_cnt - 1;
      if (imem_req) begin
        if (mem_cnt != 0) overlap <= overlap + 1;
        if (mem_lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= BASE + 32'(imem_addr);
        end else begin
          mem_cnt  <= mem_lat - 1;
          mem_addr <= imem_addr;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic r, input logic [PC_BITS-1:0] p);
    stall_F        = s;
    redirect_valid = r;
    redirect_pc    = p;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    set_in(1'b0, 1'b0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a negedge where the presented instruction has the given PC.
  task automatic find_valid(input logic [PC_BITS-1:0] target, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (F_valid === 1'b1 && F_pc === target) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    mem_lat = 1;
    rst = 1'b1;
    set_in(1'b1, 1'b1, 5'd7);
    tick();
    tick();
    @(negedge clk);
    checks++; if (F_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", F_valid); end
    checks++; if (F_inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h expected %h", F_inst, NOP); end
    checks++; if (F_pc !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", F_pc); end
    checks++; if (perf_fetched !== 16'd0) begin errors++; $display("FAIL reset_perf: got %0d expected 0", perf_fetched); end
    rst = 1'b0;
    set_in(1'b0, 1'b0, '0);
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin
      errors++; $display("FAIL reset_first_req: got req=%b addr=%0d expected req=1 addr=0", imem_req, imem_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_sequential;
    logic               exp_req, exp_v;
    logic [PC_BITS-1:0] exp_addr, exp_pc;
    mem_lat = 1;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_req  = (c % 2 == 1);
      exp_addr = PC_BITS'((c - 1) / 2);
      exp_v    = (c % 2 == 1) && (c >= 3);
      exp_pc   = PC_BITS'((c - 3) / 2);
      checks++; if (imem_req !== exp_req || (exp_req && imem_addr !== exp_addr)) begin
        errors++; $display("FAIL seq_req c%0d: got req=%b addr=%0d expected req=%b addr=%0d", c, imem_req, imem_addr, exp_req, exp_addr);
      end
      checks++; if (F_valid !== exp_v) begin
        errors++; $display("FAIL seq_valid c%0d: got %b expected %b", c, F_valid, exp_v);
      end
      if (exp_v) begin
        checks++; if (F_pc !== exp_pc || F_inst !== BASE + 32'(exp_pc)) begin
          errors++; $display("FAIL seq_data c%0d: got pc=%0d inst=%h expected pc=%0d inst=%h", c, F_pc, F_inst, exp_pc, BASE + 32'(exp_pc));
        end
      end else begin
        checks++; if (F_inst !== NOP) begin errors++; $display("FAIL seq_nop c%0d: got %h expected %h", c, F_inst, NOP); end
      end
      tick();
    end
    $display("test_sequential done");
  endtask

  task automatic test_stall;
    bit ok;
    mem_lat = 1;
    do_reset();
    find_valid(5'd3, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_reach: got no F_pc=3 expected F_pc=3 within 40 cycles"); end
    stall_F = 1'b1;
    #1;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (F_valid !== 1'b1 || F_pc !== 5'd3 || F_inst !== BASE + 32'd3 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold k%0d: got v=%b pc=%0d inst=%h req=%b expected v=1 pc=3 inst=%h req=0", k, F_valid, F_pc, F_inst, imem_req, BASE + 32'd3);
      end
    end
    stall_F = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd4) begin
      errors++; $display("FAIL stall_release: got req=%b addr=%0d expected req=1 addr=4", imem_req, imem_addr);
    end
    find_valid(5'd4, 10, ok);
    checks++; if (!ok || F_inst !== BASE + 32'd4) begin
      errors++; $display("FAIL stall_next: got ok=%b inst=%h expected ok=1 inst=%h", ok, F_inst, BASE + 32'd4);
    end
    tick();
    $display("test_stall done");
  endtask

  task automatic test_redirect_wait;
    bit seen_req, seen_v;
    mem_lat = 3;
    do_reset();
    tick();
    set_in(1'b0, 1'b1, 5'd17);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req_in_redirect: got %b expected 0", imem_req); end
    tick();
    set_in(1'b0, 1'b0, '0);
    seen_req = 1'b0;
    seen_v   = 1'b0;
    for (int i = 0; i < 30 && !seen_v; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && !seen_req) begin
        seen_req = 1'b1;
        checks++; if (imem_addr !== 5'd17) begin errors++; $display("FAIL rdw_addr: got %0d expected 17", imem_addr); end
      end
      if (F_valid === 1'b1) begin
        seen_v = 1'b1;
        checks++; if (F_pc !== 5'd17 || F_inst !== 32'h1000_0011) begin
          errors++; $display("FAIL rdw_deliver: got pc=%0d inst=%h expected pc=17 inst=10000011", F_pc, F_inst);
        end
      end
    end
    checks++; if (!seen_req || !seen_v) begin
      errors++; $display("FAIL rdw_timeout: got req=%b valid=%b expected both 1", seen_req, seen_v);
    end
    mem_lat = 1;
    $display("test_redirect_wait done");
  endtask

  task automatic test_redirect_stall;
    bit ok;
    mem_lat = 1;
    do_reset();
    find_valid(5'd0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rds_reach: got no delivery expected F_pc=0"); end
    set_in(1'b1, 1'b1, 5'd9);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rds_req: got %b expected 0", imem_req); end
    tick();
    set_in(1'b0, 1'b0, '0);
    @(negedge clk);
    checks++; if (F_valid !== 1'b0 || F_inst !== NOP) begin
      errors++; $display("FAIL rds_flush: got v=%b inst=%h expected v=0 inst=%h", F_valid, F_inst, NOP);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd9) begin
      errors++; $display("FAIL rds_next_req: got req=%b addr=%0d expected req=1 addr=9", imem_req, imem_addr);
    end
    find_valid(5'd9, 10, ok);
    checks++; if (!ok || F_inst !== 32'h1000_0009) begin
      errors++; $display("FAIL rds_deliver: got ok=%b inst=%h expected ok=1 inst=10000009", ok, F_inst);
    end
    tick();
    $display("test_redirect_stall done");
  endtask

  task automatic test_wrap;
    logic [PC_BITS-1:0] exp_pcs [3];
    int n;
    exp_pcs = '{5'd31, 5'd0, 5'd1};
    mem_lat = 1;
    do_reset();
    set_in(1'b0, 1'b1, 5'd31);
    tick();
    set_in(1'b0, 1'b0, '0);
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      @(negedge clk);
      if (F_valid === 1'b1) begin
        checks++; if (F_pc !== exp_pcs[n] || F_inst !== BASE + 32'(exp_pcs[n])) begin
          errors++; $display("FAIL wrap_deliver%0d: got pc=%0d inst=%h expected pc=%0d inst=%h", n, F_pc, F_inst, exp_pcs[n], BASE + 32'(exp_pcs[n]));
        end
        n++;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", n); end
    tick();
    $display("test_wrap done");
  endtask

  task automatic test_perf;
    bit ok;
    logic [15:0] exp_perf;
    exp_perf = PERF_EN ? 16'd5 : 16'd0;
    mem_lat = 1;
    do_reset();
    find_valid(5'd0, 20, ok);
    stall_F = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stall_F = 1'b0;
    find_valid(5'd1, 20, ok);
    set_in(1'b0, 1'b1, 5'd20);
    tick();
    set_in(1'b0, 1'b0, '0);
    find_valid(5'd23, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL perf_reach: got no F_pc=23 expected delivery"); end
    tick();
    @(negedge clk);
    checks++; if (perf_fetched !== exp_perf) begin
      errors++; $display("FAIL perf_count: got %0d expected %0d", perf_fetched, exp_perf);
    end
    $display("test_perf done");
  endtask

  task automatic test_random;
    logic [PC_BITS-1:0] m_pc, prev_pc;
    logic [31:0]        prev_inst;
    logic [15:0]        m_perf;
    logic               prev_v, prev_s, prev_r, s, r;
    logic [PC_BITS-1:0] p;
    int                 idle;
    mem_lat = 1;
    do_reset();
    m_pc = '0; m_perf = '0; prev_v = 1'b0; prev_s = 1'b0; prev_r = 1'b0;
    prev_pc = '0; prev_inst = NOP; idle = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 8);
      p = PC_BITS'($urandom_range(0, 31));
      mem_lat = int'($urandom_range(1, 3));
      set_in(s, r, p);
      @(negedge clk);
      if (F_valid !== 1'b1) begin
        checks++; if (F_inst !== NOP || (prev_v && prev_s && !prev_r)) begin
          errors++; $display("FAIL rnd_idle c%0d: got v=%b inst=%h expected inst=%h held=%b", cyc, F_valid, F_inst, NOP, prev_v && prev_s && !prev_r);
        end
      end else if (!prev_v) begin
        checks++; if (F_pc !== m_pc || F_inst !== BASE + 32'(m_pc)) begin
          errors++; $display("FAIL rnd_deliver c%0d: got pc=%0d inst=%h expected pc=%0d inst=%h", cyc, F_pc, F_inst, m_pc, BASE + 32'(m_pc));
        end
        m_pc = m_pc + 1'b1;
      end else begin
        checks++; if (prev_r || !prev_s || F_pc !== prev_pc || F_inst !== prev_inst) begin
          errors++; $display("FAIL rnd_hold c%0d: got pc=%0d inst=%h expected pc=%0d inst=%h (stalled=%b redirect=%b)", cyc, F_pc, F_inst, prev_pc, prev_inst, prev_s, prev_r);
        end
      end
      if (r || (F_valid === 1'b1 && s)) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_req_block c%0d: got req=%b expected 0", cyc, imem_req); end
      end else if (F_valid === 1'b1) begin
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rnd_req_consume c%0d: got req=%b expected 1", cyc, imem_req); end
      end
      if (imem_req === 1'b1) begin
        checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c%0d: got %0d expected %0d", cyc, imem_addr, m_pc); end
      end
      checks++; if (perf_fetched !== (PERF_EN ? m_perf : 16'd0)) begin
        errors++; $display("FAIL rnd_perf c%0d: got %0d expected %0d", cyc, perf_fetched, PERF_EN ? m_perf : 16'd0);
      end
      if (F_valid === 1'b1 || r) idle = 0;
      else idle++;
      if (idle > 12) begin
        checks++; errors++;
        $display("FAIL rnd_progress c%0d: got %0d idle cycles expected at most 12", cyc, idle);
        idle = 0;
      end
      if (F_valid === 1'b1 && !s && !r && m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
      if (r) m_pc = p;
      prev_v = (F_valid === 1'b1); prev_s = s; prev_r = r;
      prev_pc = F_pc; prev_inst = F_inst;
      tick();
    end
    set_in(1'b0, 1'b0, '0);
    checks++; if (overlap != 0) begin errors++; $display("FAIL rnd_outstanding: got %0d overlapping requests expected 0", overlap); end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap();
    test_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
